// File: rtl/booth_prod_acc.sv
// ----------------------------------------------------------------------------
// booth_prod_acc
//
// Dot-product accumulator that sits behind an 8x8 Booth multiplier. A run
// starts with in_start while IDLE. The block then accepts in_len signed 16-bit
// products (in_len = 0 means 16) and adds each one into a signed ACC_W-bit
// accumulator. When the last product has been added, it presents the final sum
// until the consumer takes it.
//
// Each addition is done at ACC_W+1 bits, so an out-of-range result can always
// be detected. Any overflow in a run sets the sticky o_ovf flag, which stays
// set until the next in_start.
//
// Configuration macro: BOOTH_ACC_SAT_EN
//   defined   : an overflowing sum clamps to the most positive or most
//               negative ACC_W-bit value
//   undefined : an overflowing sum wraps (the low ACC_W bits are kept)
//
// Parameters
//   ACC_W          signed accumulator width, 17..32 (default 20)
//
// Ports
//   in_clk         clock; all state changes on the rising edge
//   in_rst_n       synchronous active-low reset
//   in_start       start a run (acted on only in IDLE)
//   in_len         number of products in the run, 0 encodes 16
//   in_prod_valid  in_prod carries a product
//   in_prod        signed product word
//   o_prod_ready   high exactly while accumulating (decoded from state only)
//   o_acc          running and final accumulated sum (signed)
//   o_acc_valid    o_acc holds a final result
//   in_acc_ready   consumer takes the result
//   o_ovf          sticky overflow flag for the current run
//   o_busy         high while accumulating or holding a result
// ----------------------------------------------------------------------------
module booth_prod_acc #(
  parameter int ACC_W = 20
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_start,
  input  logic [3:0]              in_len,
  input  logic                    in_prod_valid,
  input  logic signed [15:0]      in_prod,
  output logic                    o_prod_ready,
  output logic signed [ACC_W-1:0] o_acc,
  output logic                    o_acc_valid,
  input  logic                    in_acc_ready,
  output logic                    o_ovf,
  output logic                    o_busy
);

  // One guard bit above the accumulator, so every sum is exact.
  localparam int SUM_W = ACC_W + 1;
  localparam int EXT_W = SUM_W - 16;

`ifdef BOOTH_ACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [4:0]       cnt_r;
  logic [4:0]       len_load_s;
  logic [SUM_W-1:0] prod_ext_s;
  logic [SUM_W-1:0] sum_s;
  logic [ACC_W-1:0] next_acc_s;
  logic             sum_ovf_s;

  // The exact sum leaves the ACC_W range when its guard bit and its top
  // accumulator bit disagree.
  function automatic logic range_ovf(input logic guard_bit, input logic top_bit);
    return guard_bit ^ top_bit;
  endfunction

  // Decode the run length; the 4-bit code 0 stands for a full 16-product run.
  always_comb begin
    if (in_len == 4'd0) begin
      len_load_s = 5'd16;
    end else begin
      len_load_s = {1'b0, in_len};
    end
  end

  // Extended-width addition, overflow detection and the wrap/clamp choice.
  always_comb begin
    prod_ext_s = {{EXT_W{in_prod[15]}}, in_prod};
    sum_s      = {o_acc[ACC_W-1], o_acc} + prod_ext_s;
    sum_ovf_s  = range_ovf(sum_s[SUM_W-1], sum_s[SUM_W-2]);
`ifdef BOOTH_ACC_SAT_EN
    if (sum_ovf_s) begin
      // The guard bit carries the true sign of the sum, so it picks the rail.
      if (sum_s[SUM_W-1]) begin
        next_acc_s = ACC_MIN;
      end else begin
        next_acc_s = ACC_MAX;
      end
    end else begin
      next_acc_s = sum_s[ACC_W-1:0];
    end
`else
    next_acc_s = sum_s[ACC_W-1:0];
`endif
  end

  // Products are taken only in ACC. Ready depends on the state alone, so the
  // upstream can rely on it without any combinational loop through valid.
  always_comb begin
    o_prod_ready = (state_r == ST_ACC);
  end

  // Control FSM with the accumulator, the overflow flag and the registered
  // status outputs.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 5'd0;
      o_acc       <= {ACC_W{1'b0}};
      o_ovf       <= 1'b0;
      o_acc_valid <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_start) begin
            state_r     <= ST_ACC;
            cnt_r       <= len_load_s;
            o_acc       <= {ACC_W{1'b0}};
            o_ovf       <= 1'b0;
            o_acc_valid <= 1'b0;
            o_busy      <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_ACC: begin
          if (in_prod_valid) begin
            o_acc <= next_acc_s;
            o_ovf <= o_ovf | sum_ovf_s;
            cnt_r <= cnt_r - 5'd1;
            // The final sum is already in o_acc when valid rises.
            if (cnt_r == 5'd1) begin
              state_r     <= ST_DONE;
              o_acc_valid <= 1'b1;
            end else begin
              state_r     <= ST_ACC;
            end
          end else begin
            state_r <= ST_ACC;
          end
        end
        ST_DONE: begin
          // A start that arrives together with ready is dropped.
          if (in_acc_ready) begin
            state_r     <= ST_IDLE;
            o_acc_valid <= 1'b0;
            o_busy      <= 1'b0;
          end else begin
            state_r     <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= 5'd0;
          o_acc_valid <= 1'b0;
          o_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_prod_acc.sv
// ----------------------------------------------------------------------------
// tb_booth_prod_acc
//
// Test bench for booth_prod_acc. Expected results are pushed into a queue when
// a run's last product is issued. A separate monitor for each instance pops an
// entry when o_acc_valid rises and compares it with the result. While valid
// stays high, the monitor checks that the result holds.
//
// The reference model is signed integer arithmetic with an explicit range
// check, followed by a clamp or a wrap.
//
// The main instance uses the default ACC_W = 20. A second instance with
// ACC_W = 17 covers overflow, because 16 products can never overflow 20 bits.
// ----------------------------------------------------------------------------
module tb_booth_prod_acc;

  localparam int W  = 20;
  localparam int WS = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, prod_valid, acc_ready;
  logic [3:0] len;
  logic signed [15:0] prod;
  logic prod_ready, acc_valid, ovf, busy;
  logic signed [W-1:0] acc;

  logic s_start, s_prod_valid, s_acc_ready;
  logic [3:0] s_len;
  logic signed [15:0] s_prod;
  logic s_prod_ready, s_acc_valid, s_ovf, s_busy;
  logic signed [WS-1:0] s_acc;

  booth_prod_acc #(.ACC_W(W)) dut (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(start), .in_len(len),
    .in_prod_valid(prod_valid), .in_prod(prod), .o_prod_ready(prod_ready),
    .o_acc(acc), .o_acc_valid(acc_valid), .in_acc_ready(acc_ready),
    .o_ovf(ovf), .o_busy(busy)
  );

  booth_prod_acc #(.ACC_W(WS)) dut_s (
    .in_clk(clk), .in_rst_n(rst_n), .in_start(s_start), .in_len(s_len),
    .in_prod_valid(s_prod_valid), .in_prod(s_prod), .o_prod_ready(s_prod_ready),
    .o_acc(s_acc), .o_acc_valid(s_acc_valid), .in_acc_ready(s_acc_ready),
    .o_ovf(s_ovf), .o_busy(s_busy)
  );

  typedef struct {
    longint acc;
    bit     ovf;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t s_exp_q[$];
  int   prods[$];

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic longint lim_hi(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint lim_lo(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic bit out_of_range(input longint s, input int w);
    return (s > lim_hi(w)) || (s < lim_lo(w));
  endfunction

  function automatic longint fit(input longint s, input int w);
`ifdef BOOTH_ACC_SAT_EN
    if (s > lim_hi(w)) return lim_hi(w);
    if (s < lim_lo(w)) return lim_lo(w);
    return s;
`else
    longint m;
    m = s & ((longint'(1) <<< w) - 1);
    if (m > lim_hi(w)) m = m - (longint'(1) <<< w);
    return m;
`endif
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the main instance.
  initial begin : mon_main
    bit   prev;
    exp_t cur;
    prev    = 1'b0;
    cur.acc = 0;
    cur.ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (acc_valid === 1'b1) begin
        if (!prev) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: acc=%0d appeared with no run pending", acc);
          end else begin
            cur = exp_q.pop_front();
            chk("result_acc", acc, cur.acc);
            chk("result_ovf", ovf, cur.ovf);
          end
        end else begin
          chk("hold_acc", acc, cur.acc);
          chk("hold_ovf", ovf, cur.ovf);
        end
      end
      prev = (acc_valid === 1'b1);
    end
  end

  // Monitor for the narrow instance.
  initial begin : mon_small
    bit   prev;
    exp_t cur;
    prev    = 1'b0;
    cur.acc = 0;
    cur.ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (s_acc_valid === 1'b1) begin
        if (!prev) begin
          if (s_exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL s_unexpected_result: acc=%0d appeared with no run pending", s_acc);
          end else begin
            cur = s_exp_q.pop_front();
            chk("s_result_acc", s_acc, cur.acc);
            chk("s_result_ovf", s_ovf, cur.ovf);
          end
        end else begin
          chk("s_hold_acc", s_acc, cur.acc);
          chk("s_hold_ovf", s_ovf, cur.ovf);
        end
      end
      prev = (s_acc_valid === 1'b1);
    end
  end

  // One run on the main instance, fed from prods[]: random valid gaps, a
  // DONE hold of 'hold' cycles, and an optional start pulse on the ready edge.
  task automatic run_main(input logic [3:0] l, input int gap_pct, input int hold,
                          input bit start_on_ready);
    int     n;
    int     g;
    longint m_acc;
    bit     m_ovf;
    exp_t   e;
    n     = (l == 4'd0) ? 16 : int'(l);
    m_acc = 0;
    m_ovf = 1'b0;
    start = 1'b1; len = l; acc_ready = 1'b0;
    cyc();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_ready", prod_ready, 1);
    chk("start_clr_acc", acc, 0);
    chk("start_clr_ovf", ovf, 0);
    for (int i = 0; i < n; i++) begin
      g = 0;
      while (($urandom_range(99) < gap_pct) && (g < 8)) begin
        prod_valid = 1'b0;
        prod       = 16'($urandom);
        start      = 1'($urandom_range(1));
        cyc();
        g++;
        chk("gap_ready", prod_ready, 1);
        chk("gap_hold_acc", acc, m_acc);
      end
      start      = 1'b0;
      prod_valid = 1'b1;
      prod       = 16'(prods[i]);
      if (out_of_range(m_acc + longint'(prods[i]), W)) m_ovf = 1'b1;
      m_acc = fit(m_acc + longint'(prods[i]), W);
      if (i == n - 1) begin
        e.acc = m_acc;
        e.ovf = m_ovf;
        exp_q.push_back(e);
      end
      cyc();
    end
    prod_valid = 1'b0;
    chk("last_latency_valid", acc_valid, 1);
    for (int h = 0; h < hold; h++) begin
      start      = 1'($urandom_range(1));
      prod_valid = 1'($urandom_range(1));
      prod       = 16'($urandom);
      cyc();
      chk("done_valid", acc_valid, 1);
      chk("done_busy", busy, 1);
      chk("done_not_ready", prod_ready, 0);
    end
    acc_ready = 1'b1; start = start_on_ready; prod_valid = 1'b0;
    cyc();
    acc_ready = 1'b0; start = 1'b0;
    chk("idle_busy", busy, 0);
    chk("idle_valid", acc_valid, 0);
    chk("idle_keep_acc", acc, m_acc);
    chk("idle_keep_ovf", ovf, m_ovf);
  endtask

  // One back-to-back run on the narrow instance, fed from prods[].
  task automatic run_small(input logic [3:0] l);
    int     n;
    longint m_acc;
    bit     m_ovf;
    exp_t   e;
    n     = (l == 4'd0) ? 16 : int'(l);
    m_acc = 0;
    m_ovf = 1'b0;
    s_start = 1'b1; s_len = l;
    cyc();
    s_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_prod_valid = 1'b1;
      s_prod       = 16'(prods[i]);
      if (out_of_range(m_acc + longint'(prods[i]), WS)) m_ovf = 1'b1;
      m_acc = fit(m_acc + longint'(prods[i]), WS);
      if (i == n - 1) begin
        e.acc = m_acc;
        e.ovf = m_ovf;
        s_exp_q.push_back(e);
      end
      cyc();
    end
    s_prod_valid = 1'b0;
    chk("s_latency_valid", s_acc_valid, 1);
    s_acc_ready = 1'b1;
    cyc();
    s_acc_ready = 1'b0;
    chk("s_idle_busy", s_busy, 0);
    chk("s_keep_acc", s_acc, m_acc);
    chk("s_keep_ovf", s_ovf, m_ovf);
  endtask

  function automatic int pick_prod();
    case ($urandom_range(3))
      0:       return 32767;
      1:       return -32768;
      default: return int'($urandom_range(65535)) - 32768;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 4'd0; prod_valid = 1'b0; prod = 16'sd0;
    acc_ready = 1'b0;
    s_start = 1'b0; s_len = 4'd0; s_prod_valid = 1'b0; s_prod = 16'sd0;
    s_acc_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_acc", acc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_valid", acc_valid, 0);
    chk("rst_ready", prod_ready, 0);
    chk("rst_busy", busy, 0);
    chk("s_rst_acc", s_acc, 0);
    rst_n = 1'b1;

    // Products presented while IDLE are ignored.
    prod_valid = 1'b1; prod = 16'sd1234;
    repeat (3) begin
      cyc();
      chk("idle_ignore_acc", acc, 0);
      chk("idle_ignore_ready", prod_ready, 0);
      chk("idle_ignore_busy", busy, 0);
    end
    prod_valid = 1'b0;

    // Basic run: 100 - 50 + 7.
    prods = '{100, -50, 7};
    run_main(4'd3, 0, 0, 1'b0);

    // Length code 0 (16 products of 16384) with random gaps.
    prods.delete();
    repeat (16) prods.push_back(16384);
    run_main(4'd0, 40, 1, 1'b0);

    // Backpressure: 5 cycles without ready, start pulses, start on ready edge.
    prods.delete();
    repeat (5) prods.push_back(pick_prod());
    run_main(4'd5, 0, 5, 1'b1);

    // Reset after 2 of 4 products: the partial run is dropped.
    start = 1'b1; len = 4'd4;
    cyc();
    start = 1'b0; prod_valid = 1'b1; prod = 16'sd1000;
    cyc();
    cyc();
    prod_valid = 1'b0; rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("midrst_acc", acc, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_valid", acc_valid, 0);
    chk("midrst_ready", prod_ready, 0);
    chk("midrst_busy", busy, 0);
    repeat (3) cyc();
    chk("midrst_no_result", acc_valid, 0);

    // Randomized runs on the main instance.
    for (int r = 0; r < 20; r++) begin
      logic [3:0] l;
      int         n;
      l = 4'($urandom_range(15));
      n = (l == 4'd0) ? 16 : int'(l);
      prods.delete();
      repeat (n) prods.push_back(pick_prod());
      run_main(l, int'($urandom_range(50)), int'($urandom_range(3)),
               1'($urandom_range(1)));
    end

    // Narrow instance: the lower bound exactly, then negative and positive
    // overflow, with a return into range to show that the flag is sticky.
    prods = '{-32768, -32768};
    run_small(4'd2);
    prods = '{-32768, -32768, -32768};
    run_small(4'd3);
    prods = '{32767, 32767, 32767, -32768};
    run_small(4'd4);
    for (int r = 0; r < 6; r++) begin
      logic [3:0] l;
      int         n;
      l = 4'($urandom_range(15));
      n = (l == 4'd0) ? 16 : int'(l);
      prods.delete();
      repeat (n) prods.push_back(pick_prod());
      run_small(l);
    end

    repeat (3) cyc();
    chk("queue_drained", exp_q.size(), 0);
    chk("s_queue_drained", s_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
